// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types for the instruction-memory loader; IMEM_LOADER_CHECKSUM_EN adds the CHECK state
package types_pkg;

  localparam int DATA_BUS     = 32;
  localparam int LOADER_LEN_W = 16;

  typedef logic [7:0] BYTE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } LOADER_STATE;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream into little-endian 32-bit words
module byte_packer
  import types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  BYTE                 in_byte,
  output logic [DATA_BUS-1:0] word,
  output logic                word_done
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // Count bytes within the word and shift each new byte in from the top,
  // so after three bytes byte 0 sits in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (clr) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (in_valid) begin
      cnt   <= cnt + 2'd1;
      shift <= {in_byte, shift[23:8]};
    end
  end

  // The fourth byte completes the word combinationally so the caller can
  // register it on the same edge that accepts the byte.
  assign word      = {in_byte, shift};
  assign word_done = in_valid && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream writer for instruction memory; IMEM_LOADER_CHECKSUM_EN enables trailing XOR checksum
module imem_loader
  import types_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_BUS-1:0]   wr_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  LOADER_STATE             state;
  LOADER_STATE             state_nxt;
  logic [LOADER_LEN_W-1:0] len;
  logic [LOADER_LEN_W-1:0] len_full;
  logic [LOADER_LEN_W-1:0] word_cnt;
  logic                    accept;
  logic                    start_take;
  logic                    data_beat;
  logic                    len_too_big;
  logic                    last_word;
  logic                    word_done;
  logic [DATA_BUS-1:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  BYTE                     csum;
`endif

  assign accept     = byte_valid && byte_ready;
  assign start_take = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign data_beat  = accept && (state == S_DATA);
  // Length as it will be once the high byte in flight is captured.
  assign len_full    = {byte_data, len[7:0]};
  assign len_too_big = 33'(len_full) > (33'd1 << ADDR_WIDTH);
  assign last_word   = (word_cnt == len - LOADER_LEN_W'(1));

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_take),
    .in_valid (data_beat),
    .in_byte  (byte_data),
    .word     (word),
    .word_done(word_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode; terminal states wait for a new start.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CHECK;
`else
            state_nxt = S_DONE;
`endif
          end else if (len_too_big) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done    = (state == S_DONE);
  assign error   = (state == S_ERR);
  assign cpu_rst = busy | error;

  // Length capture, word counter and the registered memory write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      word_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_take) word_cnt <= '0;
      if (accept && state == S_LEN_LO) len[7:0]  <= byte_data;
      if (accept && state == S_LEN_HI) len[15:8] <= byte_data;
      if (word_done) begin
        wr_en    <= 1'b1;
        wr_data  <= word;
        wr_addr  <= ADDR_WIDTH'(word_cnt);
        word_cnt <= word_cnt + LOADER_LEN_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of data bytes only; length bytes never reach DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             csum <= 8'd0;
    else if (start_take) csum <= 8'd0;
    else if (data_beat)  csum <= csum ^ byte_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN
module tb_imem_loader;

  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;

  int compared   = 0;
  int mismatched = 0;
  int wr_n       = 0;
  int base;
  logic [AW-1:0] log_addr [64];
  logic [31:0]   log_data [64];
  logic [7:0]    stall_bytes [12];
  logic [31:0]   ovf_words [4];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_n < 64) begin
        log_addr[wr_n] = wr_addr;
        log_data[wr_n] = wr_data;
      end
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited     = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waited < 16) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("byte_ready_handshake", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_cpu_rst"},    32'(cpu_rst),    32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, "_wr_data"},    wr_data,         32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    stall_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
                    8'h5A, 8'h5A, 8'hA5, 8'hA5};
    ovf_words   = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};

    // Reset values
    idle(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    idle(2);
    check_idle_outputs("post_reset");

    // Basic load, with a byte offered alongside start in IDLE
    base       = wr_n;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    @(posedge clk);
    #1;
    start      = 1'b0;
    byte_valid = 1'b0;
    check("start_busy",       32'(busy),       32'd1);
    check("start_cpu_rst",    32'(cpu_rst),    32'd1);
    check("start_byte_ready", 32'(byte_ready), 32'd1);
    send_len(16'd2);
    send_word(32'h00500013);
    send_word(32'h00100093);
    check("basic_last_wr_en",   32'(wr_en),   32'd1);
    check("basic_last_wr_addr", 32'(wr_addr), 32'd1);
    check("basic_last_wr_data", wr_data,      32'h00100093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("basic_busy_before_csum", 32'(busy), 32'd1);
    send_byte(8'hC0);
`endif
    check("basic_done",    32'(done),    32'd1);
    check("basic_busy",    32'(busy),    32'd0);
    check("basic_cpu_rst", 32'(cpu_rst), 32'd0);
    idle(2);
    check("basic_count", 32'(wr_n - base), 32'd2);
    check("basic_addr0", 32'(log_addr[base]),     32'd0);
    check("basic_data0", log_data[base],          32'h00500013);
    check("basic_addr1", 32'(log_addr[base + 1]), 32'd1);
    check("basic_data1", log_data[base + 1],      32'h00100093);

    // Zero length
    base = wr_n;
    do_start();
    check("zero_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00);
    check("zero_done_early", 32'(done), 32'd0);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("zero_wait_csum", 32'(done), 32'd0);
    send_byte(8'h00);
`endif
    check("zero_done",  32'(done),  32'd1);
    check("zero_busy",  32'(busy),  32'd0);
    check("zero_wr_en", 32'(wr_en), 32'd0);
    idle(2);
    check("zero_count", 32'(wr_n - base), 32'd0);

    // Overflow: N=5 exceeds four words
    do_start();
    send_len(16'd5);
    check("ovf_error",      32'(error),      32'd1);
    check("ovf_byte_ready", 32'(byte_ready), 32'd0);
    check("ovf_cpu_rst",    32'(cpu_rst),    32'd1);
    check("ovf_busy",       32'(busy),       32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    idle(3);
    byte_valid = 1'b0;
    check("ovf_error_held",   32'(error),   32'd1);
    check("ovf_cpu_rst_held", 32'(cpu_rst), 32'd1);
    check("ovf_done",         32'(done),    32'd0);

    // Reload at full capacity: N=4 writes addresses 0..3
    base = wr_n;
    do_start();
    check("reload_error_cleared", 32'(error),   32'd0);
    check("reload_cpu_rst",       32'(cpu_rst), 32'd1);
    send_len(16'd4);
    for (int w = 0; w < 4; w++) send_word(ovf_words[w]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check("reload_done",    32'(done),    32'd1);
    check("reload_cpu_rst_released", 32'(cpu_rst), 32'd0);
    idle(2);
    check("reload_count", 32'(wr_n - base), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check("reload_addr", 32'(log_addr[base + w]), 32'(w));
      check("reload_data", log_data[base + w],      ovf_words[w]);
    end

    // Stalls: N=3 with valid gaps
    base = wr_n;
    do_start();
    idle(2);
    send_len(16'd3);
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 3));
      send_byte(stall_bytes[i]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle(2);
    send_byte(8'h22);
`endif
    check("stall_done", 32'(done), 32'd1);
    idle(4);
    check("stall_count", 32'(wr_n - base), 32'd3);
    check("stall_data0", log_data[base],     32'hDEADBEEF);
    check("stall_data1", log_data[base + 1], 32'h01234567);
    check("stall_data2", log_data[base + 2], 32'hA5A55A5A);
    check("stall_addr2", 32'(log_addr[base + 2]), 32'd2);

    // Reset after six data bytes
    base = wr_n;
    do_start();
    send_len(16'd2);
    send_word(32'h44332211);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    idle(2);
    rst = 1'b0;
    idle(3);
    check("midrst_count", 32'(wr_n - base), 32'd1);
    check("midrst_addr0", 32'(log_addr[base]), 32'd0);
    check("midrst_data0", log_data[base],      32'h44332211);
    check("midrst_done",  32'(done),           32'd0);

    // Single word after the aborted session
    base = wr_n;
    do_start();
    send_len(16'd1);
    send_word(32'h04030201);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h04);
`endif
    check("one_done", 32'(done), 32'd1);
    idle(2);
    check("one_count", 32'(wr_n - base), 32'd1);
    check("one_data",  log_data[base],   32'h04030201);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch still writes the image
    base = wr_n;
    do_start();
    send_len(16'd1);
    send_word(32'h04030201);
    send_byte(8'h05);
    check("csum_bad_error",   32'(error),   32'd1);
    check("csum_bad_done",    32'(done),    32'd0);
    check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    idle(2);
    check("csum_bad_count", 32'(wr_n - base), 32'd1);
    check("csum_bad_addr",  32'(log_addr[base]), 32'd0);
    check("csum_bad_data",  log_data[base],      32'h04030201);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
